// File: rtl/braun_mult_pipe.sv
// Pipelined Braun / Baugh-Wooley array multiplier with stream handshake
// and an optional running accumulator on the output register.
module braun_mult_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int ACC_W  = 2 * WIDTH + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy
);

    localparam int PW = 2 * WIDTH;
    localparam int G  = (WIDTH + STAGES - 1) / STAGES;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sg;
        logic             ac;
        logic [PW-1:0]    sum;
    } beat_t;

    // One partial-product row; in signed mode the terms that pair exactly
    // one operand MSB with a non-MSB bit are complemented.
    function automatic logic [PW-1:0] pp_row(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sg,
        input int               i
    );
        logic [PW-1:0] r;
        logic          t;
        r = '0;
        for (int j = 0; j < WIDTH; j++) begin
            t = a[j] & b[i];
            if (sg && ((i == WIDTH - 1) != (j == WIDTH - 1)))
                t = ~t;
            r[i+j] = t;
        end
        return r;
    endfunction

    // Row-group k sum; group 0 also carries the signed correction constant.
    function automatic logic [PW-1:0] group_sum(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sg,
        input int               k
    );
        logic [PW-1:0] s;
        s = '0;
        if (k == 0 && sg)
            s = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
        for (int i = 0; i < WIDTH; i++) begin
            if (i / G == k)
                s = s + pp_row(a, b, sg, i);
        end
        return s;
    endfunction

    function automatic logic [ACC_W-1:0] extend(
        input logic [PW-1:0] p,
        input logic          sg
    );
        logic [ACC_W-1:0] r;
        r = {ACC_W{sg & p[PW-1]}};
        r[PW-1:0] = p;
        return r;
    endfunction

    logic              adv;
    logic [ACC_W-1:0]  acc_q;
    logic [STAGES-1:0] held;
    beat_t             st_in  [STAGES];
    beat_t             st_out [STAGES];
    beat_t             last;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign out_data = acc_q;
    assign busy     = |held;

    assign st_in[0] = '{
        v:   in_valid,
        a:   in_a,
        b:   in_b,
        sg:  in_signed,
        ac:  in_acc,
        sum: '0
    };

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign st_out[k] = '{
            v:   st_in[k].v,
            a:   st_in[k].a,
            b:   st_in[k].b,
            sg:  st_in[k].sg,
            ac:  st_in[k].ac,
            sum: st_in[k].sum
                 + group_sum(st_in[k].a, st_in[k].b, st_in[k].sg, k)
        };

        if (k == 0) begin : g_head
            assign held[0] = out_valid;
        end else begin : g_reg
            beat_t q;

            always_ff @(posedge clk) begin
                if (rst)
                    q <= '0;
                else if (adv)
                    q <= st_out[k-1];
            end

            assign st_in[k] = q;
            assign held[k]  = q.v;
        end
    end

    assign last = st_out[STAGES-1];

    // Accumulator and output register are the same state: every load
    // both presents the value and makes it the new running sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            acc_q     <= '0;
        end else if (adv) begin
            out_valid <= last.v;
            if (last.v) begin
                if (last.ac)
                    acc_q <= acc_q + extend(last.sum, last.sg);
                else
                    acc_q <= extend(last.sum, last.sg);
            end
        end
    end

endmodule

// File: doc/braun_mult_pipe.md
Name: braun_mult_pipe

Overview:
- Parametrised, pipelined Braun/Baugh-Wooley array multiplier with a valid/ready stream interface.
- Per-transaction signed or unsigned mode, plus an optional accumulate mode that sums successive products.
- Succeeds the fixed 8x8 combinational Braun array. Sits behind the tt_um top-level wrapper, which maps ui_in/uio_in onto operands and uo_out/uio_out onto the result.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- STAGES, 2, number of register stages from input acceptance to output register (>=1). The array is partitioned into STAGES row-groups of ceil(WIDTH/STAGES) partial-product rows each.
- ACC_W, 2*WIDTH+4, accumulator/result width (>=2*WIDTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_acc  in  1  1 = add product to running accumulator, 0 = replace it.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  result. Product is sign- or zero-extended to ACC_W per in_signed.
- busy  out  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over all other activity and takes effect the same edge:
  - every stage valid bit cleared; accumulator cleared to 0;
  - out_valid=0, out_data=0, busy=0;
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight beats; no partial result is ever presented.
- Pipeline advance:
  - adv = !out_valid || out_ready.
  - in_ready = adv (combinational from out_valid and out_ready only; no dependency on in_valid).
  - When adv=0, all stages hold data and valid unchanged; out_data is stable while out_valid=1 and out_ready=0.
- Acceptance: a beat is accepted on an edge where in_valid && in_ready. Operands, in_signed and in_acc travel with the beat.
- Latency: a beat accepted at edge N, with no stall, gives out_valid=1 in the cycle after edge N+STAGES-1. STAGES=1 means the result is visible the cycle after acceptance. Throughput is one beat per cycle.
- Stage k (0..STAGES-1) adds its row-group of partial products into a carry-save/ripple partial sum.
- Signed mode uses Baugh-Wooley complemented MSB terms plus correction constant. The product is exact in 2*WIDTH bits for both modes, including -2^(WIDTH-1) * -2^(WIDTH-1).
- Final stage (output register load, which occurs when adv=1 and the last internal stage is valid):
  - ext = product extended to ACC_W (sign-extend if the beat's in_signed=1, else zero-extend).
  - out_data = in_acc ? acc + ext : ext, computed mod 2^ACC_W (wraps, no saturation).
  - acc <= the same value.
- Accumulator updates only on the output register load. Bubbles and stalls do not change acc.
- Output register valid bit:
  - set on load;
  - cleared when out_ready=1 and no new beat loads that edge;
  - simultaneous drain and load keeps out_valid=1 with new data.
- Mode mixing: in_signed may differ between consecutive beats. Each beat uses its own flag. acc is simply the ACC_W-bit sum.
- Full pipeline with out_ready=0: at most STAGES beats are held, and in_ready=0. No beat is dropped or duplicated.
- Empty pipeline: busy=0, out_valid=0, in_ready=1.

Test Plan:
- Reset, then WIDTH=8, STAGES=2, unsigned, out_ready=1: a=0xFF, b=0xFF accepted at edge N -> out_valid the cycle after edge N+1, out_data=0x0FE01; busy back to 0 one cycle after drain.
- Signed corners: (-128)*(-128) -> 0x04000; (-128)*127 -> 0xFC080 (ACC_W=20 sign-extended); (-1)*1 -> 0xFFFFF.
- Accumulate: beats 3*4 (acc=0), 5*6 (acc=1), 2*2 (acc=1) -> outputs 12, 42, 46. Then 7*7 (acc=0) -> 49 (accumulator replaced).
- Backpressure: stream 6 back-to-back beats with out_ready held 0 from cycle 3 to 8 -> in_ready falls once STAGES beats are held; out_data stable while stalled; all 6 results emerge in order with no loss or duplication.
- Reset mid-stream: 2 beats in flight, rst=1 for one edge -> next cycle out_valid=0, busy=0; the following 2*3 beat with acc=1 yields 6 (accumulator cleared).
- Random regression, WIDTH in {4, 8, 11}, STAGES in {1, 3}: random in_valid/out_ready toggling, mixed signed/acc -> scoreboard against a reference model, exact match per beat.
